// File: rtl/kanagawa_valid_merge_buffer.sv
// Merges CHANNELS never-stalling valid-only streams through per-channel FIFOs
// onto one ready/valid output, round-robin arbitrated and tagged with the source channel.
module kanagawa_valid_merge_buffer #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int AF_MARGIN = 4,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       valid_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       almost_full_out,
  output logic [CHANNELS-1:0]       overflow_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [CW-1:0]             channel_out
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] AF_TH   = CNTW'(DEPTH - AF_MARGIN);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);

  logic [WIDTH-1:0] r_mem    [CHANNELS][DEPTH];
  logic [PW-1:0]    r_rd_ptr [CHANNELS];
  logic [PW-1:0]    r_wr_ptr [CHANNELS];
  logic [CNTW-1:0]  r_count  [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_chan;
  logic [CW-1:0]    r_rr;

  logic                w_free;
  logic                w_found;
  logic [CW-1:0]       w_grant;
  logic [CW-1:0]       w_rr_next;
  logic [WIDTH-1:0]    w_rd_data;
  logic [CHANNELS-1:0] w_pop;
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_af;

  always_comb begin
    w_free    = !r_valid || ready_in;
    w_found   = 1'b0;
    w_grant   = '0;
    w_rd_data = '0;
    w_pop     = '0;
    w_wr      = '0;
    w_af      = '0;
    // First non-empty FIFO at or after rr_ptr, wrapping.
    for (int k = 0; k < CHANNELS; k++) begin
      if (!w_found && r_count[(int'(r_rr) + k) % CHANNELS] != '0) begin
        w_found = 1'b1;
        w_grant = CW'((int'(r_rr) + k) % CHANNELS);
      end
    end
    w_rr_next = (int'(w_grant) + 1 == CHANNELS) ? '0 : w_grant + CW'(1);
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(w_grant) == c) w_rd_data = r_mem[c][r_rd_ptr[c]];
      w_pop[c] = w_free && w_found && (int'(w_grant) == c);
      // A full FIFO still takes the beat if its head leaves this cycle.
      w_wr[c]  = valid_in[c] && (r_count[c] != DEPTH_C || w_pop[c]);
      w_af[c]  = r_count[c] >= AF_TH;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!rst && w_wr[c]) r_mem[c][r_wr_ptr[c]] <= data_in[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
      r_ovf   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_rr    <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wr[c])  r_wr_ptr[c] <= r_wr_ptr[c] + PTR_ONE;
        if (w_pop[c]) r_rd_ptr[c] <= r_rd_ptr[c] + PTR_ONE;
        case ({w_wr[c], w_pop[c]})
          2'b10:   r_count[c] <= r_count[c] + CNT_ONE;
          2'b01:   r_count[c] <= r_count[c] - CNT_ONE;
          default: r_count[c] <= r_count[c];
        endcase
        if (valid_in[c] && !w_wr[c]) r_ovf[c] <= 1'b1;
      end
      if (w_free) begin
        r_valid <= w_found;
        if (w_found) begin
          r_data <= w_rd_data;
          r_chan <= w_grant;
          r_rr   <= w_rr_next;
        end
      end
    end
  end

  assign almost_full_out = w_af;
  assign overflow_out    = r_ovf;
  assign valid_out       = r_valid;
  assign data_out        = r_data;
  assign channel_out     = r_chan;
endmodule

// File: tb/tb_kanagawa_valid_merge_buffer.sv
// Bench for kanagawa_valid_merge_buffer: queue-based reference model plus
// directed and randomized scenarios, two channels of 32-bit data, depth 16.
module tb_kanagawa_valid_merge_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CH    = 2;
  localparam int AFM   = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          rst = 1'b1;
  logic [CH-1:0] valid_in = '0;
  logic [63:0]   data_in = '0;
  logic          ready_in = 1'b0;
  logic [CH-1:0] almost_full_out, overflow_out;
  logic          valid_out;
  logic [31:0]   data_out;
  logic [0:0]    channel_out;

  kanagawa_valid_merge_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CH), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .almost_full_out(almost_full_out), .overflow_out(overflow_out),
    .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out),
    .channel_out(channel_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: FIFO contents as queues, one hold slot, rr pointer
  logic [31:0] mq [CH][$];
  logic        m_hv;
  logic [31:0] m_hd;
  int          m_hc;
  int          m_rr;
  logic [CH-1:0] m_ovf;
  logic [35:0] m_acc_q[$];

  // scoreboard
  logic [35:0] exp_q[$];
  logic [35:0] obs_q[$];

  function automatic logic [CH-1:0] model_af();
    logic [CH-1:0] af;
    for (int c = 0; c < CH; c++) af[c] = (mq[c].size() >= DEPTH - AFM);
    return af;
  endfunction

  task automatic model_edge(input logic r, input logic [CH-1:0] v, input logic [63:0] d, input logic rdy);
    if (r) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      m_hv = 0; m_hd = 0; m_hc = 0; m_rr = 0; m_ovf = '0;
    end else begin
      if (m_hv && rdy) m_acc_q.push_back({4'(m_hc), m_hd});
      if (!m_hv || rdy) begin
        m_hv = 0;
        for (int k = 0; k < CH; k++) begin
          int c;
          c = (m_rr + k) % CH;
          if (!m_hv && mq[c].size() > 0) begin
            m_hd = mq[c].pop_front();
            m_hc = c;
            m_hv = 1;
            m_rr = (c + 1) % CH;
          end
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (v[c]) begin
          if (mq[c].size() < DEPTH) mq[c].push_back(d[c*32 +: 32]);
          else m_ovf[c] = 1'b1;
        end
      end
    end
  endtask

  // driver: apply inputs on negedge, log accepted beats, advance model at posedge
  task automatic drive(input logic r, input logic [CH-1:0] v, input logic [31:0] d0,
                       input logic [31:0] d1, input logic rdy);
    @(negedge clk);
    rst = r; valid_in = v; data_in = {d1, d0}; ready_in = rdy;
    #1;
    if (!r && valid_out && ready_in) obs_q.push_back({3'b000, channel_out, data_out});
    @(posedge clk);
    model_edge(r, v, {d1, d0}, rdy);
    #1;
  endtask

  task automatic start_test();
    drive(1'b1, '0, 0, 0, 1'b0);
    exp_q.delete(); obs_q.delete(); m_acc_q.delete();
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b11, 32'hdead, 32'hbeef, 1'b1);
    n_cmp++;
    if (valid_out !== 1'b0 || data_out !== 32'd0 || channel_out !== 1'b0 ||
        almost_full_out !== 2'b00 || overflow_out !== 2'b00) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h ch=%b af=%b ovf=%b, want all zero",
               valid_out, data_out, channel_out, almost_full_out, overflow_out);
    end
  endtask

  task automatic test_single_stream();
    start_test();
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, (i < 10) ? 2'b01 : 2'b00, i, 0, 1'b1);
      n_cmp++;
      if (valid_out !== m_hv || almost_full_out !== model_af() || overflow_out !== m_ovf ||
          (m_hv && {channel_out, data_out} !== {m_hc[0], m_hd})) begin
        n_err++;
        $display("FAIL single_cycle%0d: got v=%b d=%0d ch=%b af=%b ovf=%b, want v=%b d=%0d ch=%0d af=%b ovf=%b",
                 i, valid_out, data_out, channel_out, almost_full_out, overflow_out,
                 m_hv, m_hd, m_hc, model_af(), m_ovf);
      end
      // first output one cycle after the first write, then no gaps
      if (i >= 1 && i <= 10) begin
        n_cmp++;
        if (valid_out !== 1'b1 || data_out !== 32'(i - 1)) begin
          n_err++;
          $display("FAIL single_latency%0d: got v=%b d=%0d, want v=1 d=%0d", i, valid_out, data_out, i - 1);
        end
      end
    end
    for (int i = 0; i < 10; i++) exp_q.push_back({4'd0, 32'(i)});
    n_cmp++;
    if (obs_q != exp_q) begin
      n_err++;
      $display("FAIL single_order: got %0d beats, want %0d beats 0..9 ch0", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_alternate();
    start_test();
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, (i < 10) ? 2'b11 : 2'b00, i, 100 + i, 1'b1);
      n_cmp++;
      if (valid_out !== m_hv || almost_full_out !== model_af() || overflow_out !== m_ovf ||
          (m_hv && {channel_out, data_out} !== {m_hc[0], m_hd})) begin
        n_err++;
        $display("FAIL alt_cycle%0d: got v=%b d=%0d ch=%b, want v=%b d=%0d ch=%0d",
                 i, valid_out, data_out, channel_out, m_hv, m_hd, m_hc);
      end
    end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({4'd0, 32'(i)});
      exp_q.push_back({4'd1, 32'(100 + i)});
    end
    n_cmp++;
    if (obs_q != exp_q) begin
      n_err++;
      $display("FAIL alt_order: got %0d beats (first %h), want 20 alternating 0,100,1,101..",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 36'h0);
    end
  endtask

  task automatic test_fill_overflow();
    start_test();
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 2'b01, i, 0, 1'b0);
      n_cmp++;
      if (valid_out !== m_hv || almost_full_out !== model_af() || overflow_out !== m_ovf ||
          (m_hv && {channel_out, data_out} !== {m_hc[0], m_hd})) begin
        n_err++;
        $display("FAIL fill_cycle%0d: got v=%b d=%0d af=%b ovf=%b, want v=%b d=%0d af=%b ovf=%b",
                 i, valid_out, data_out, almost_full_out, overflow_out, m_hv, m_hd, model_af(), m_ovf);
      end
    end
    n_cmp++;
    if (overflow_out !== 2'b01 || almost_full_out !== 2'b01) begin
      n_err++;
      $display("FAIL fill_flags: got ovf=%b af=%b, want ovf=01 af=01", overflow_out, almost_full_out);
    end
    for (int i = 0; i < 20; i++) drive(1'b0, 2'b00, 0, 0, 1'b1);
    for (int i = 0; i < 17; i++) exp_q.push_back({4'd0, 32'(i)});
    n_cmp++;
    if (obs_q != exp_q) begin
      n_err++;
      $display("FAIL fill_drain: got %0d beats, want 17 beats 0..16", obs_q.size());
    end
    n_cmp++;
    if (overflow_out !== 2'b01 || almost_full_out !== 2'b00 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL fill_sticky: got ovf=%b af=%b v=%b, want ovf=01 af=00 v=0",
               overflow_out, almost_full_out, valid_out);
    end
  endtask

  task automatic test_full_pop();
    start_test();
    for (int i = 0; i < 17; i++) drive(1'b0, 2'b10, 0, 200 + i, 1'b0);
    n_cmp++;
    if (almost_full_out !== 2'b10 || overflow_out !== 2'b00) begin
      n_err++;
      $display("FAIL fullpop_setup: got af=%b ovf=%b, want af=10 ovf=00", almost_full_out, overflow_out);
    end
    drive(1'b0, 2'b10, 0, 217, 1'b1);
    n_cmp++;
    if (overflow_out !== 2'b00 || overflow_out !== m_ovf) begin
      n_err++;
      $display("FAIL fullpop_accept: got ovf=%b, want 00", overflow_out);
    end
    for (int i = 0; i < 20; i++) drive(1'b0, 2'b00, 0, 0, 1'b1);
    for (int i = 0; i < 18; i++) exp_q.push_back({4'd1, 32'(200 + i)});
    n_cmp++;
    if (obs_q != exp_q) begin
      n_err++;
      $display("FAIL fullpop_order: got %0d beats, want 18 beats 200..217 ch1", obs_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic rp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    start_test();
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b01, 50 + i, 0, 1'b0);
    drive(1'b0, 2'b10, 0, 60, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 2'b00, 0, 0, rp[i]);
      n_cmp++;
      if (valid_out !== m_hv || (m_hv && {channel_out, data_out} !== {m_hc[0], m_hd})) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got v=%b d=%0d ch=%b, want v=%b d=%0d ch=%0d",
                 i, valid_out, data_out, channel_out, m_hv, m_hd, m_hc);
      end
    end
    // 50 held, then rr moves to ch1 (60), then ch0 again
    exp_q.push_back({4'd0, 32'd50}); exp_q.push_back({4'd1, 32'd60});
    exp_q.push_back({4'd0, 32'd51}); exp_q.push_back({4'd0, 32'd52});
    n_cmp++;
    if (obs_q != exp_q) begin
      n_err++;
      $display("FAIL hold_order: got %0d beats, want 50,60,51,52", obs_q.size());
    end
  endtask

  task automatic test_random();
    start_test();
    for (int i = 0; i < 300; i++) begin
      logic [CH-1:0] v;
      v[0] = ($urandom_range(0, 3) != 0);
      v[1] = ($urandom_range(0, 2) == 0);
      drive(1'b0, (i < 260) ? v : 2'b00, $urandom, $urandom, ($urandom_range(0, 2) == 0) || i >= 260);
      n_cmp++;
      if (valid_out !== m_hv || almost_full_out !== model_af() || overflow_out !== m_ovf ||
          (m_hv && {channel_out, data_out} !== {m_hc[0], m_hd})) begin
        n_err++;
        $display("FAIL rand_cycle%0d: got v=%b d=%h ch=%b af=%b ovf=%b, want v=%b d=%h ch=%0d af=%b ovf=%b",
                 i, valid_out, data_out, channel_out, almost_full_out, overflow_out,
                 m_hv, m_hd, m_hc, model_af(), m_ovf);
      end
    end
    n_cmp++;
    if (obs_q != m_acc_q) begin
      n_err++;
      $display("FAIL rand_stream: got %0d beats, want %0d", obs_q.size(), m_acc_q.size());
    end
  endtask

  task automatic test_mid_reset();
    start_test();
    for (int i = 0; i < 18; i++) drive(1'b0, (i < 5) ? 2'b11 : 2'b01, i, 300 + i, 1'b0);
    n_cmp++;
    if (overflow_out !== 2'b01 || valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_setup: got ovf=%b v=%b, want ovf=01 v=1", overflow_out, valid_out);
    end
    drive(1'b1, 2'b11, 1, 2, 1'b1);
    n_cmp++;
    if (valid_out !== 1'b0 || almost_full_out !== 2'b00 || overflow_out !== 2'b00) begin
      n_err++;
      $display("FAIL midrst_clear: got v=%b af=%b ovf=%b, want 0 00 00", valid_out, almost_full_out, overflow_out);
    end
    drive(1'b0, 2'b11, 7, 8, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 0, 0, 1'b1);
    exp_q.push_back({4'd0, 32'd7}); exp_q.push_back({4'd1, 32'd8});
    n_cmp++;
    if (obs_q != exp_q) begin
      n_err++;
      $display("FAIL midrst_traffic: got %0d beats (first %h), want ch0:7 then ch1:8",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 36'h0);
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_alternate();
    test_fill_overflow();
    test_full_pop();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/kanagawa_valid_merge_buffer.md
# kanagawa_valid_merge_buffer

Parametrised successor to the valid-only mailbox adapters used around no-backpressure Kanagawa classes. It accepts CHANNELS independent valid-only streams, such as `PlusFour_result_out` or `OneMore_a_out`-style callback outputs, which can never be stalled. Each stream is buffered in its own FIFO, and the FIFOs are merged round-robin onto one ready/valid output tagged with the source channel. Per-channel almost-full flags let upstream logic throttle before data is lost, and sticky overflow flags record any loss.

## Interface
Parameters:
- WIDTH, 32, payload bits per beat (>=1)
- DEPTH, 16, entries per channel FIFO (power of two, >=2)
- CHANNELS, 2, number of input streams (1..16)
- AF_MARGIN, 4, almost-full asserts when free entries <= AF_MARGIN (0..DEPTH-1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  CHANNELS  bit c marks a beat on channel c this cycle; there is no backpressure on inputs
- data_in  in  CHANNELS*WIDTH  channel c payload at bits [c*WIDTH +: WIDTH]
- almost_full_out  out  CHANNELS  bit c = (count_c >= DEPTH-AF_MARGIN)
- overflow_out  out  CHANNELS  sticky; bit c set when a channel c beat was dropped
- valid_out  out  1  output register holds a beat
- ready_in  in  1  consumer accepts the beat when valid_out & ready_in
- data_out  out  WIDTH  payload of the held beat
- channel_out  out  max(1,$clog2(CHANNELS))  source channel of the held beat

## Operation
- Per-channel storage: a circular FIFO with read pointer, write pointer and occupancy counter count_c.
  - Pointer width is $clog2(DEPTH). Pointers wrap modulo DEPTH.
  - count_c width is $clog2(DEPTH+1).
- Write rule: valid_in[c] writes data into FIFO c when count_c < DEPTH, or when FIFO c is popped in the same cycle (full plus simultaneous pop accepts the write).
- Overflow: any other valid_in[c] beat is dropped.
  - Dropped beats are never written and pointers are unchanged.
  - overflow_out[c] is set and stays set until rst. Other channels are unaffected.
- Output stage: a single register holding valid_out, data_out and channel_out. It is "free" when !valid_out, or when valid_out & ready_in.
- Arbitration: when the output register is free, choose the first non-empty FIFO scanning from rr_ptr upward, wrapping modulo CHANNELS.
  - Pop the chosen FIFO and load the register with that beat and its channel.
  - Set rr_ptr to (granted+1) mod CHANNELS. rr_ptr is unchanged if nothing is granted.
  - If the register is free and all FIFOs are empty, valid_out goes low.
- Hold: while valid_out & !ready_in, data_out and channel_out are stable and no FIFO is popped.
- Occupancy: count_c changes by +1 on write, -1 on pop, 0 on both.
- Almost-full: almost_full_out is a function of registered count_c only, with no combinational path from valid_in.
- Ordering: per-channel order is preserved. No ordering is guaranteed across channels beyond round-robin fairness.

## Timing
- Reset state, effective on the clock edge where rst=1:
  - all FIFOs empty, rr_ptr=0
  - valid_out=0, data_out=0, channel_out=0
  - almost_full_out=0, overflow_out=0
- valid_in and ready_in are ignored while rst=1. Asserting rst mid-operation discards all buffered and held beats within one cycle.
- Latency: a beat written at edge N into an empty FIFO, with the output register free, is on valid_out/data_out after edge N+1. There is no same-cycle bypass.
- Throughput: one beat per cycle on the output while ready_in stays high and any FIFO is non-empty.
- almost_full_out[c] updates the cycle after the write or pop that crosses the threshold.
- Input side must allow for this lag: an upstream that reacts to almost_full_out within one cycle needs AF_MARGIN >= 1 plus its own pipeline depth to avoid loss.
- Exact fill/drain: DEPTH beats fit per channel while the output is stalled.
  - Once the output register holds one extra beat, DEPTH+1 beats can be absorbed in total.
  - Beat DEPTH+2 with no pop overflows.

## Test plan
- CHANNELS=2, DEPTH=16, ready_in=1.
  - Stimulus: valid_in[0] with data 0..9 on consecutive cycles.
  - Response: data_out 0..9 in order, channel_out=0, first valid_out one cycle after the first write, no gaps, overflow_out=0.
- Both channels valid every cycle for 10 cycles; ch0 data i, ch1 data 100+i; ready_in=1.
  - Response: output alternates ch0,ch1 starting ch0: 0,100,1,101,...
  - Per-channel order preserved.
- ready_in=0; 18 beats on ch0.
  - Response: almost_full_out[0] rises the cycle after count reaches 12.
  - 17 beats retained (16 in FIFO + 1 in output register); beat 18 dropped; overflow_out[0]=1 and stays set.
  - After ready_in=1, exactly 17 beats drain, values 0..16.
- Full FIFO with a simultaneous pop.
  - Setup: fill ch1 to DEPTH with ready_in=0.
  - Stimulus: raise ready_in and drive valid_in[1] in the same cycle.
  - Response: the write is accepted, overflow_out[1] stays 0, all beats emerge in order.
- Backpressure hold.
  - Stimulus: toggle ready_in 1,0,0,1 while beats are pending.
  - Response: data_out and channel_out are unchanged while valid_out & !ready_in; no beat is duplicated or lost.
- Mid-stream reset.
  - Setup: 5 beats buffered on each channel, overflow_out[0] set.
  - Stimulus: rst=1 for one cycle.
  - Response: next cycle valid_out=0, almost_full_out=0, overflow_out=0; subsequent traffic starts with rr_ptr=0.
